// File: rtl/grey_div_counter.sv
// Prescaled Gray-code up/down counter; down counting is built only with GREY_DIV_DOWN_EN defined.
// Latency: grey/tick/wrap are registered and update one cycle after the qualifying edge.
// Backpressure: none; en stalls the prescaler and count, and load overrides counting.
module grey_div_counter #(
    parameter int WIDTH = 6,
    parameter int DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] grey,
    output logic             tick,
    output logic             wrap
);

    logic [DIV_W-1:0] p_q, p_d;
    logic [WIDTH-1:0] grey_q, grey_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_nxt;

    function automatic logic [WIDTH-1:0] grey2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2grey(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifndef GREY_DIV_DOWN_EN
    logic dir_unused;
    assign dir_unused = dir;
`endif

    always_comb begin
        p_d     = p_q;
        grey_d  = grey_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        bin_cur = grey2bin(grey_q);
        bin_nxt = bin_cur + WIDTH'(1);
        if (load) begin
            grey_d = load_val;
            p_d    = '0;
        end else if (en) begin
            // >= rather than == so a div lowered below the current phase fires immediately
            if (p_q >= div) begin
                p_d    = '0;
                tick_d = 1'b1;
`ifdef GREY_DIV_DOWN_EN
                if (dir) begin
                    bin_nxt = bin_cur - WIDTH'(1);
                    wrap_d  = (bin_cur == '0);
                end else begin
                    wrap_d  = (bin_cur == '1);
                end
`else
                wrap_d = (bin_cur == '1);
`endif
                grey_d = bin2grey(bin_nxt);
            end else begin
                p_d = p_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q    <= '0;
            grey_q <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            grey_q <= grey_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign grey = grey_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_grey_div_counter.sv
// Bench for grey_div_counter: vector table plus reference-model scoreboard sequences.
module tb_grey_div_counter;
    localparam int W = 6;
    localparam int D = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic         dir = 1'b0;
    logic [D-1:0] div = '0;
    logic [W-1:0] load_val = '0;
    wire  [W-1:0] grey;
    wire          tick;
    wire          wrap;

    grey_div_counter #(.WIDTH(W), .DIV_W(D)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .load(load),
        .load_val(load_val), .dir(dir), .grey(grey), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic         rst, en, load, dir;
        logic [D-1:0] div;
        logic [W-1:0] load_val;
        logic [W-1:0] grey;
        logic         tick, wrap;
    } vec_t;

    typedef struct {
        logic [W-1:0] grey;
        logic         tick, wrap;
        string        name;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain binary count, shown as Gray on the output
    logic [W-1:0] mb = '0;
    logic [D-1:0] mp = '0;
    logic         mt = 1'b0;
    logic         mw = 1'b0;

    function automatic logic [W-1:0] gray_inv(input logic [W-1:0] g);
        logic [W-1:0] bv;
        for (int b = 0; b < 2**W; b++) begin
            bv = W'(b);
            if ((bv ^ (bv >> 1)) == g) return bv;
        end
        return '0;
    endfunction

    task automatic model_step();
        logic dn;
`ifdef GREY_DIV_DOWN_EN
        dn = dir;
`else
        dn = 1'b0;
`endif
        mt = 1'b0;
        mw = 1'b0;
        if (!rst) begin
            mb = '0;
            mp = '0;
        end else if (load) begin
            mb = gray_inv(load_val);
            mp = '0;
        end else if (en) begin
            if (mp >= div) begin
                mp = '0;
                mt = 1'b1;
                if (dn) begin
                    mw = (mb == '0);
                    mb = mb - W'(1);
                end else begin
                    mw = (mb == '1);
                    mb = mb + W'(1);
                end
            end else begin
                mp = mp + D'(1);
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic d,
                         input logic [D-1:0] dv, input logic [W-1:0] lv);
        rst = r; en = e; load = l; dir = d; div = dv; load_val = lv;
    endtask

    task automatic check_edge();
        exp_t x;
        @(posedge clk);
        #1;
        x = sb.pop_front();
        n_cmp++;
        if (grey !== x.grey || tick !== x.tick || wrap !== x.wrap) begin
            n_bad++;
            $display("FAIL %s: got grey=%b tick=%b wrap=%b, expected grey=%b tick=%b wrap=%b",
                     x.name, grey, tick, wrap, x.grey, x.tick, x.wrap);
        end
    endtask

    task automatic cycle(input string name);
        exp_t x;
        model_step();
        x.grey = mb ^ (mb >> 1);
        x.tick = mt;
        x.wrap = mw;
        x.name = name;
        sb.push_back(x);
        check_edge();
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    vec_t vecs[15];

    initial begin
        int first_wrap;
        int ticks;
        exp_t x;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'b111111, 6'b000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000001, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000011, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000010, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000010, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000010, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000010, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000110, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 6'b100000, 6'b100000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000000, 6'b000000, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 6'b000000, 6'b000000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 6'b000000, 6'b000000, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 6'b000000, 6'b000001, 1'b1, 1'b0};
`ifdef GREY_DIV_DOWN_EN
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 6'b000000, 6'b000000, 1'b1, 1'b0};
`else
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 6'b000000, 6'b000011, 1'b1, 1'b0};
`endif
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 6'b111111, 6'b000000, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].dir, vecs[i].div, vecs[i].load_val);
            model_step();
            x.grey = vecs[i].grey;
            x.tick = vecs[i].tick;
            x.wrap = vecs[i].wrap;
            x.name = $sformatf("vec%0d", i);
            sb.push_back(x);
            check_edge();
        end

        // Long divide-by-17 run through the first wrap
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        cycle("div17_rst");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        first_wrap = 0;
        ticks = 0;
        for (int i = 1; i <= 1100; i++) begin
            cycle("div17_run");
            if (tick) ticks++;
            if (wrap && first_wrap == 0) first_wrap = i;
        end
        check_val("div17_first_wrap_cycle", first_wrap, 1088);
        check_val("div17_tick_count", ticks, 64);

        // Load mid-count, then wrap from 100000 after a full prescaler period
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        cycle("load_rst");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        for (int i = 0; i < 10; i++) cycle("load_pre");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd16, 6'b100000);
        cycle("load_strobe");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        for (int i = 0; i < 17; i++) cycle("load_post");
        check_val("load_wrap_flag", int'(wrap), 1);
        check_val("load_wrap_grey", int'(grey), 0);

        // Lower div below the current phase
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        cycle("divchg_rst");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd16, '0);
        for (int i = 0; i < 12; i++) cycle("divchg_pre");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, '0);
        cycle("divchg_now");
        check_val("divchg_immediate_tick", int'(tick), 1);
        for (int i = 0; i < 10; i++) cycle("divchg_post");

        // Reset with load and en asserted mid-count
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, '0);
        for (int i = 0; i < 6; i++) cycle("rstmid_pre");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 6'b101010);
        cycle("rstmid_assert");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, '0);
        for (int i = 0; i < 4; i++) cycle("rstmid_post");
        check_val("rstmid_first_tick", int'(tick), 1);

        // Randomised mix
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  D'($urandom_range(0, 5)), W'($urandom_range(0, 63)));
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grey_div_counter.md
GREY_DIV_COUNTER -- requirements
Module: grey_div_counter

Interface
REQ-001 Parameter WIDTH, default 6: width of the Gray-code output counter, legal range 2..16.
REQ-002 Parameter DIV_W, default 5: width of the runtime divisor input, legal range 1..16.
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 Port en  input  1: count enable for prescaler and Gray counter.
REQ-006 Port div  input  DIV_W: divide ratio minus one; one advance every div+1 enabled cycles.
REQ-007 Port load  input  1: synchronous load strobe for the Gray counter.
REQ-008 Port load_val  input  WIDTH: Gray-coded value written on load.
REQ-009 Port dir  input  1: count direction, 0 = up, 1 = down (see Configuration).
REQ-010 Port grey  output  WIDTH: registered Gray-code count.
REQ-011 Port tick  output  1: registered one-cycle pulse, high in the cycle grey shows a newly advanced value.
REQ-012 Port wrap  output  1: registered one-cycle pulse, high with tick when the count rolls over.

Function
REQ-013 Prescaler: internal binary counter p, width DIV_W, not visible at ports.
REQ-014 Edge with en=1 and p<div: p<=p+1, tick<=0, wrap<=0, grey holds.
REQ-015 Edge with en=1 and p>=div: p<=0, grey<=next(grey), tick<=1; ">=" covers div lowered below p mid-count.
REQ-016 div=0 with en=1: tick high and grey advancing every cycle.
REQ-017 en=0 and load=0: p and grey hold; tick<=0, wrap<=0.
REQ-018 next(g) up = bin2grey((grey2bin(g)+1) mod 2^WIDTH), binary-reflected Gray code.
REQ-019 next(g) down = bin2grey((grey2bin(g)-1) mod 2^WIDTH).
REQ-020 Each advance changes exactly one bit of grey; grey changes at no other time except load and reset.
REQ-021 wrap<=1 on an up advance from 1 followed by WIDTH-1 zeros to all-zero, or a down advance from all-zero to 1 followed by WIDTH-1 zeros; otherwise wrap<=0.
REQ-022 load=1: grey<=load_val, p<=0, tick<=0, wrap<=0, regardless of en; load has priority over counting in the same cycle.
REQ-023 load_val is not required to be a reachable state; any WIDTH-bit value is accepted and counting continues from it per REQ-018/019.
REQ-024 div and dir are sampled every cycle; a change takes effect at the next edge with no glitch on grey.
REQ-025 Latency: tick and new grey are visible one cycle after the edge that meets p>=div; no combinational path from inputs to outputs.

Reset
REQ-026 rst=0 at a rising edge: grey<=0, p<=0, tick<=0, wrap<=0.
REQ-027 Reset has priority over load and en; a reset mid-count discards the prescaler phase, and the first tick after release occurs div+1 enabled cycles later.

Configuration
REQ-028 Macro GREY_DIV_DOWN_EN: when defined, dir selects direction per REQ-009 and REQ-019.
REQ-029 GREY_DIV_DOWN_EN undefined: dir port remains present but is ignored; counter counts up only, and down-count logic is not synthesised.

Verification
REQ-030 WIDTH=6, DIV_W=5, div=16, en=1 from reset: tick every 17 cycles; grey 000000, 000001, 000011, 000010, 000110 ...; first wrap on tick 64 (cycle 1088), grey 100000 -> 000000.
REQ-031 div=0, en=1: tick high every cycle, grey advances each cycle; drop en for 3 cycles -> grey holds, tick=0; resume -> advance on the next cycle.
REQ-032 div=16, p=10, load=1, load_val=100000: grey=100000, tick=0; next tick after 17 cycles gives grey=000000 with wrap=1.
REQ-033 div=16, p=12, change div to 4: advance at the next edge (p>=div), then tick every 5 cycles.
REQ-034 GREY_DIV_DOWN_EN defined, dir=1, div=0 from reset: grey 000000 -> 100000 with wrap=1, then 100001, 100011 ...; same stimulus without the macro counts up.
REQ-035 rst=0 asserted together with load=1 and en=1 mid-count: grey=0, tick=0, wrap=0 on the next cycle; load ignored.
